// File: rtl/fetch_decode_pkg.sv
// Shared types for the CHIP-8 front end: operation indices, fetch FSM states, reset PC.
package fetch_decode_pkg;

  localparam logic [11:0] PC_RESET_DEFAULT = 12'h200;

  typedef enum logic [7:0] {
    OP_NOP     = 8'd0,  OP_CLS     = 8'd1,  OP_RET     = 8'd2,  OP_JP      = 8'd3,
    OP_JP_V0   = 8'd4,  OP_CALL    = 8'd5,  OP_SE_IMM  = 8'd6,  OP_SE_REG  = 8'd7,
    OP_SNE_IMM = 8'd8,  OP_SNE_REG = 8'd9,  OP_LD_IMM  = 8'd10, OP_LD_REG  = 8'd11,
    OP_LD_I    = 8'd12, OP_LD_VX_DT= 8'd13, OP_LD_KEY  = 8'd14, OP_LD_DT   = 8'd15,
    OP_LD_ST   = 8'd16, OP_LD_FONT = 8'd17, OP_LD_BCD  = 8'd18, OP_STORE   = 8'd19,
    OP_LOAD    = 8'd20, OP_ADD_IMM = 8'd21, OP_ADD     = 8'd22, OP_RSVD    = 8'd23,
    OP_SUB     = 8'd24, OP_SUBN    = 8'd25, OP_OR      = 8'd26, OP_AND     = 8'd27,
    OP_XOR     = 8'd28, OP_SHR     = 8'd29, OP_SHL     = 8'd30, OP_RND     = 8'd31,
    OP_DRW     = 8'd32, OP_SKP     = 8'd33, OP_SKNP    = 8'd34
  } op_t;

  typedef enum logic [1:0] {S_HI, S_LO, S_CAP, S_VAL} fd_state_t;

endpackage

// File: rtl/fetch_decode_decoder.sv
// Combinational CHIP-8 decoder: raw instruction to operation index, immediate and register selects.
module chip8_decoder
  import fetch_decode_pkg::*;
(
  input  logic [15:0] instr,
  output op_t         opcode,
  output logic [11:0] immediate,
  output logic        illegal,
  output logic [3:0]  x_sel,
  output logic [3:0]  y_sel
);

  logic [3:0] nib;
  logic [3:0] n;
  logic [7:0] kk;

  assign nib = instr[15:12];
  assign n   = instr[3:0];
  assign kk  = instr[7:0];

  // Bnnn jumps relative to V0, so the x read port is steered to register 0
  assign x_sel = (nib == 4'hB) ? 4'h0 : instr[11:8];
  assign y_sel = instr[7:4];

  always_comb begin
    opcode  = OP_NOP;
    illegal = 1'b0;
    case (nib)
      4'h0: begin
        if (instr == 16'h00E0)      opcode = OP_CLS;
        else if (instr == 16'h00EE) opcode = OP_RET;
      end
      4'h1: opcode = OP_JP;
      4'h2: opcode = OP_CALL;
      4'h3: opcode = OP_SE_IMM;
      4'h4: opcode = OP_SNE_IMM;
      4'h5: if (n == 4'h0) opcode = OP_SE_REG;  else illegal = 1'b1;
      4'h6: opcode = OP_LD_IMM;
      4'h7: opcode = OP_ADD_IMM;
      4'h8: begin
        case (n)
          4'h0: opcode = OP_LD_REG;
          4'h1: opcode = OP_OR;
          4'h2: opcode = OP_AND;
          4'h3: opcode = OP_XOR;
          4'h4: opcode = OP_ADD;
          4'h5: opcode = OP_SUB;
          4'h6: opcode = OP_SHR;
          4'h7: opcode = OP_SUBN;
          4'hE: opcode = OP_SHL;
          default: illegal = 1'b1;
        endcase
      end
      4'h9: if (n == 4'h0) opcode = OP_SNE_REG; else illegal = 1'b1;
      4'hA: opcode = OP_LD_I;
      4'hB: opcode = OP_JP_V0;
      4'hC: opcode = OP_RND;
      4'hD: opcode = OP_DRW;
      4'hE: begin
        case (kk)
          8'h9E:   opcode = OP_SKP;
          8'hA1:   opcode = OP_SKNP;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        case (kk)
          8'h07:   opcode = OP_LD_VX_DT;
          8'h0A:   opcode = OP_LD_KEY;
          8'h15:   opcode = OP_LD_DT;
          8'h18:   opcode = OP_LD_ST;
          8'h29:   opcode = OP_LD_FONT;
          8'h33:   opcode = OP_LD_BCD;
          8'h55:   opcode = OP_STORE;
          8'h65:   opcode = OP_LOAD;
          8'h1E:   opcode = OP_ADD;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    case (nib)
      4'h0, 4'h1, 4'h2, 4'hA, 4'hB:       immediate = instr[11:0];
      4'h3, 4'h4, 4'h6, 4'h7, 4'hC:       immediate = {4'h0, kk};
      4'hD:                               immediate = {8'h00, n};
      default:                            immediate = 12'h000;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// CHIP-8 fetch/decode: two byte reads per instruction, bundle registered 3 cycles after S_HI (4 cycles min).
// Bundle is held bit-stable while stall=1; branching redirects the PC from any state.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [11:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [3:0]  reg_x_sel,
  output logic [3:0]  reg_y_sel,
  input  logic [7:0]  reg_x_val,
  input  logic [7:0]  reg_y_val,
  input  logic        stall,
  input  logic        branching,
  input  logic [11:0] branch_target,
  output logic        valid,
  output logic [15:0] instruction,
  output logic [7:0]  opcode,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [3:0]  x_idx,
  output logic [11:0] immediate,
  output logic        illegal,
  output logic [11:0] pc_out
);

  fd_state_t   state;
  logic [11:0] pc;
  logic [7:0]  hi;
  logic [15:0] cap_instr;
  op_t         dec_op;
  logic [11:0] dec_imm;
  logic        dec_illegal;
  logic [3:0]  dec_x_sel;
  logic [3:0]  dec_y_sel;
  logic        cap_active;

  assign cap_instr  = {hi, mem_data};
  assign cap_active = (state == S_CAP) && !rst;

  chip8_decoder u_decoder (
    .instr     (cap_instr),
    .opcode    (dec_op),
    .immediate (dec_imm),
    .illegal   (dec_illegal),
    .x_sel     (dec_x_sel),
    .y_sel     (dec_y_sel)
  );

  assign mem_rd    = !rst && ((state == S_HI) || (state == S_LO));
  assign mem_addr  = !mem_rd ? 12'h000 : (state == S_LO) ? pc + 12'd1 : pc;
  // Selects only drive the register file while the bundle is being captured
  assign reg_x_sel = cap_active ? dec_x_sel : 4'h0;
  assign reg_y_sel = cap_active ? dec_y_sel : 4'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HI;
      pc          <= PC_RESET;
      hi          <= 8'h00;
      valid       <= 1'b0;
      instruction <= 16'h0000;
      opcode      <= 8'h00;
      r1          <= 8'h00;
      r2          <= 8'h00;
      x_idx       <= 4'h0;
      immediate   <= 12'h000;
      illegal     <= 1'b0;
      pc_out      <= 12'h000;
    end else if (branching) begin
      pc    <= branch_target;
      valid <= 1'b0;
      state <= S_HI;
    end else begin
      case (state)
        S_HI: state <= S_LO;
        S_LO: begin
          hi    <= mem_data;
          state <= S_CAP;
        end
        S_CAP: begin
          instruction <= cap_instr;
          opcode      <= dec_op;
          r1          <= reg_x_val;
          r2          <= reg_y_val;
          x_idx       <= cap_instr[11:8];
          immediate   <= dec_imm;
          illegal     <= dec_illegal;
          pc_out      <= pc;
          valid       <= 1'b1;
          state       <= S_VAL;
        end
        S_VAL: begin
          if (!stall) begin
            pc    <= pc + 12'd2;
            valid <= 1'b0;
            state <= S_HI;
          end
        end
        default: state <= S_HI;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage of the CHIP-8 core: fetches each 16-bit big-endian instruction as two byte reads from program memory, decodes it into the execute stage's operation index (0–34), reads Vx/Vy from the register file and presents one registered instruction bundle to `execute`. It holds the bundle while `execute` stalls and redirects the PC when `execute` branches.

## Interface
Parameters:
- `PC_RESET`, default 12'h200: PC value after reset.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `mem_rd`  out  1  byte read strobe.
- `mem_addr`  out  12  byte address.
- `mem_data`  in  8  read data, valid exactly one cycle after `mem_rd`.
- `reg_x_sel`, `reg_y_sel`  out  4 each  register-file read selects.
- `reg_x_val`, `reg_y_val`  in  8 each  combinational read data.
- `stall`  in  1  execute cannot accept; hold the bundle.
- `branching`  in  1  execute is redirecting the PC.
- `branch_target`  in  12  new PC.
- `valid`  out  1  bundle is valid.
- `instruction`  out  16  raw instruction.
- `opcode`  out  8  operation index.
- `r1`, `r2`  out  8 each  V[x], V[y].
- `x_idx`  out  4  destination register index.
- `immediate`  out  12  nnn, zero-extended kk, or n.
- `illegal`  out  1  undecodable encoding.
- `pc_out`  out  12  address of the bundle's instruction.

## Operation
- State machine, 12-bit `pc`:
  - S_HI: `mem_rd`=1, `mem_addr`=pc; go to S_LO.
  - S_LO: `hi` <= `mem_data`; `mem_rd`=1, `mem_addr`=pc+1 (mod 4096); go to S_CAP.
  - S_CAP: decode {`hi`,`mem_data`}; `reg_x_sel`=hi[3:0], forced to 0 for Bnnn; `reg_y_sel`=mem_data[7:4]; register every output; `valid` <= 1; go to S_VAL.
  - S_VAL: hold all outputs. If `stall`=0: pc <= pc+2 (mod 4096), `valid` <= 0, go to S_HI.
- `branching` is checked in every state and has priority over `stall` and the normal advance. It sets pc <= `branch_target` and `valid` <= 0, discards any in-flight byte, and goes to S_HI.
- `mem_rd` is 0 in S_CAP and S_VAL, and while `rst` is high.
- Decode map (nibbles are hex):
  - 0: 00E0→1; 00EE→2; any other 0nnn→0 (NOP).
  - Flow and immediates: 1nnn→3; Bnnn→4; 2nnn→5; 3xkk→6; 5xy0→7; 4xkk→8; 9xy0→9; 6xkk→10; Annn→12; 7xkk→21; Cxkk→31; Dxyn→32.
  - 8xy_: 8xy0→11; 8xy4→22; 8xy5→24; 8xy7→25; 8xy1→26; 8xy2→27; 8xy3→28; 8xy6→29; 8xyE→30.
  - Fx__: Fx07→13; Fx0A→14; Fx15→15; Fx18→16; Fx29→17; Fx33→18; Fx55→19; Fx65→20; Fx1E→22.
  - Ex__: Ex9E→33; ExA1→34.
  - Index 23 is reserved and never emitted.
- Any other encoding (5xyN or 9xyN with N≠0; unlisted 8/E/F forms) produces `opcode`=0 and `illegal`=1. The bundle is still presented and advances normally.
- `immediate` per form: nnn for 0/1/2/A/B; {4'h0,kk} for 3/4/6/7/C; {8'h0,n} for D; 0 otherwise.
- `r1`/`r2` are sampled in S_CAP only. Register writes during S_VAL are not reflected; execute owns that hazard.

## Timing
- Reset: pc=`PC_RESET`, state S_HI, every output 0 (including `valid`, `illegal`, `mem_rd`).
- First `mem_rd` occurs on the cycle after `rst` falls.
- Minimum 4 cycles per instruction. `valid` rises 3 cycles after S_HI is entered.
- A bundle is consumed on a cycle with `valid`=1 and `stall`=0. `valid` drops on the following cycle.
- Stall may last any number of cycles; outputs stay bit-stable throughout.
- `branching` takes effect at the next edge. The first read of the target occurs one cycle after the branch cycle.
- PC wrap-around: pc=FFF fetches FFF then 000; the next pc is 001.
- `rst` asserted mid-operation overrides everything, including a simultaneous `branching`.

## Structure
- `types` package additions: enum `op_t` holding indices 0–34 (names per execute's list; 23 = OP_RSVD), `fd_state_t`, and `PC_RESET_DEFAULT`.
- Sub-module `chip8_decoder`: purely combinational, 16-bit instruction → `opcode`, `immediate`, `illegal`, select fields. The FSM lives in `fetch_decode`.

## Test plan
- Reset, with memory[200]=00, [201]=E0 → reads at 200 then 201; `valid`=1 with `opcode`=1, `pc_out`=200, 3 cycles after `rst` falls.
- 8AB5 with VA=30, VB=12 → `opcode`=24, `r1`=30, `r2`=12, `x_idx`=A; `stall` held 5 cycles → outputs unchanged; next fetch at pc+2.
- B345 with V0=07 → `reg_x_sel`=0, `r1`=07, `opcode`=4, `immediate`=345.
- `branching` with target 3FE, asserted in S_LO → in-flight byte dropped, no `valid`, next reads at 3FE and 3FF.
- 5121 → `opcode`=0, `illegal`=1; F41E → `opcode`=22, `illegal`=0; D12F → `immediate`=00F.
- Instruction at FFF → reads at FFF then 000; next pc=001.
